spmv_csr_fetch: RTL and testbench

CSR operand sequencer that sits directly upstream of the SpMV compute core. On a go pulse it loads the 17-entry row-pointer array from row-pointer RAM, then walks every nonzero: it reads value and column index, gathers the matching dense-vector element, and presents each (value, x) pair with its 0-based nonzero index to the core over a valid/ready handshake. It also drives the core's packed row-pointer bus and start pulse.

---
 rtl/spmv_pkg.sv | 23 ++
 rtl/spmv_rowptr_loader.sv | 55 +++++
 rtl/spmv_csr_fetch.sv | 145 ++++++++++++++
 tb/tb_spmv_csr_fetch.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_pkg.sv
// Shared types and sizes for the SpMV CSR operand sequencer.
// Row-pointer bundle is packed so the core sees entry i at [8i +: 8].
package spmv_pkg;
  localparam int N_ROWS = 16;
  localparam int PTR_W  = 8;
  localparam int FP_W   = 16;
  localparam int COL_W  = 4;
  localparam int N_PTR  = N_ROWS + 1;
  localparam int PA_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    RPTR,
    CHECK,
    START,
    FETCH_VC,
    FETCH_X,
    PRESENT,
    DONE
  } fetch_state_t;

  typedef logic [N_PTR-1:0][PTR_W-1:0] row_ptr_t;
endpackage

// File: rtl/spmv_rowptr_loader.sv
// Streams the row-pointer array out of RAM into a register bank
// and reports whether it forms a valid CSR prefix-sum.
module spmv_rowptr_loader
  import spmv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PTR_W-1:0] ptr_data,
  output logic             ptr_en,
  output logic [PA_W-1:0]  ptr_addr,
  output row_ptr_t         row_ptr,
  output logic             last,
  output logic             ok,
  output logic [PTR_W-1:0] nnz
);
  logic            cap;
  logic [PA_W-1:0] cap_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_en   <= 1'b0;
      ptr_addr <= '0;
      cap      <= 1'b0;
      cap_idx  <= '0;
      row_ptr  <= '0;
    end else begin
      // a read issued last cycle has its data on ptr_data now
      cap     <= ptr_en;
      cap_idx <= ptr_addr;
      if (cap) row_ptr[cap_idx] <= ptr_data;
      if (load) begin
        ptr_en   <= 1'b1;
        ptr_addr <= '0;
      end else if (ptr_en) begin
        if (ptr_addr == PA_W'(N_ROWS)) begin
          ptr_en   <= 1'b0;
          ptr_addr <= '0;
        end else begin
          ptr_addr <= ptr_addr + 1'b1;
        end
      end
    end
  end

  assign last = cap && (cap_idx == PA_W'(N_ROWS));
  assign nnz  = row_ptr[N_ROWS];

  always_comb begin
    ok = (row_ptr[0] == '0);
    for (int i = 1; i < N_PTR; i++) begin
      if (row_ptr[i] < row_ptr[i-1]) ok = 1'b0;
    end
  end
endmodule

// File: rtl/spmv_csr_fetch.sv
// CSR operand sequencer: loads row pointers, then walks every nonzero
// gathering (value, x[col]) pairs for the SpMV core.
module spmv_csr_fetch
  import spmv_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_go,
  output logic                   o_ptr_en,
  output logic [PA_W-1:0]        o_ptr_addr,
  input  logic [PTR_W-1:0]       i_ptr_data,
  output logic                   o_nz_en,
  output logic [PTR_W-1:0]       o_nz_addr,
  input  logic [FP_W-1:0]        i_val_data,
  input  logic [COL_W-1:0]       i_col_data,
  output logic                   o_x_en,
  output logic [COL_W-1:0]       o_x_addr,
  input  logic [FP_W-1:0]        i_x_data,
  output logic [N_PTR*PTR_W-1:0] o_row_ptr,
  output logic                   o_start,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [FP_W-1:0]        o_data_a,
  output logic [FP_W-1:0]        o_data_b,
  output logic [PTR_W-1:0]       o_count,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);
  fetch_state_t     state;
  logic [PTR_W-1:0] k;
  logic [PTR_W-1:0] k_nxt;
  logic [PTR_W-1:0] nnz;
  logic [FP_W-1:0]  xq;
  logic             first;
  logic             load;
  logic             last;
  logic             ok;
  row_ptr_t         row_ptr;

  assign load      = (state == IDLE) && i_go;
  assign k_nxt     = k + 1'b1;
  assign o_row_ptr = row_ptr;
  // col index only exists during FETCH_X, so the x address is combinational
  assign o_x_addr  = (state == FETCH_X) ? i_col_data : '0;
  // x arrives in the first PRESENT cycle; hold it afterwards
  assign o_data_b  = first ? i_x_data : xq;

  spmv_rowptr_loader u_loader (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (load),
    .ptr_data (i_ptr_data),
    .ptr_en   (o_ptr_en),
    .ptr_addr (o_ptr_addr),
    .row_ptr  (row_ptr),
    .last     (last),
    .ok       (ok),
    .nnz      (nnz)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      k         <= '0;
      xq        <= '0;
      first     <= 1'b0;
      o_start   <= 1'b0;
      o_nz_en   <= 1'b0;
      o_nz_addr <= '0;
      o_x_en    <= 1'b0;
      o_valid   <= 1'b0;
      o_data_a  <= '0;
      o_count   <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_start   <= 1'b0;
      o_done    <= 1'b0;
      o_nz_en   <= 1'b0;
      o_nz_addr <= '0;
      o_x_en    <= 1'b0;
      first     <= 1'b0;
      if (first) xq <= i_x_data;
      unique case (state)
        IDLE: begin
          if (i_go) begin
            state  <= RPTR;
            o_err  <= 1'b0;
            k      <= '0;
            o_busy <= 1'b1;
          end
        end
        RPTR: begin
          if (last) state <= CHECK;
        end
        CHECK: begin
          if (!ok || nnz == '0) begin
            o_err  <= !ok;
            state  <= DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end else begin
            state   <= START;
            o_start <= 1'b1;
          end
        end
        START: begin
          state     <= FETCH_VC;
          o_nz_en   <= 1'b1;
          o_nz_addr <= k;
        end
        FETCH_VC: begin
          state  <= FETCH_X;
          o_x_en <= 1'b1;
        end
        FETCH_X: begin
          state    <= PRESENT;
          o_data_a <= i_val_data;
          o_valid  <= 1'b1;
          o_count  <= k;
          first    <= 1'b1;
        end
        PRESENT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            k       <= k_nxt;
            if (k_nxt == nnz) begin
              state  <= DONE;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              state     <= FETCH_VC;
              o_nz_en   <= 1'b1;
              o_nz_addr <= k_nxt;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spmv_csr_fetch.sv
// Bench for spmv_csr_fetch: RAM models, table of row-pointer cases,
// hand sequences and random CSR matrices checked against a model.
module tb_spmv_csr_fetch;
  import spmv_pkg::*;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_go = 1'b0;
  logic              i_ready = 1'b0;
  logic              o_ptr_en;
  logic [4:0]        o_ptr_addr;
  logic [7:0]        i_ptr_data = '0;
  logic              o_nz_en;
  logic [7:0]        o_nz_addr;
  logic [15:0]       i_val_data = '0;
  logic [3:0]        i_col_data = '0;
  logic              o_x_en;
  logic [3:0]        o_x_addr;
  logic [15:0]       i_x_data = '0;
  logic [135:0]      o_row_ptr;
  logic              o_start;
  logic              o_valid;
  logic [15:0]       o_data_a;
  logic [15:0]       o_data_b;
  logic [7:0]        o_count;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  spmv_csr_fetch dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_go       (i_go),
    .o_ptr_en   (o_ptr_en),
    .o_ptr_addr (o_ptr_addr),
    .i_ptr_data (i_ptr_data),
    .o_nz_en    (o_nz_en),
    .o_nz_addr  (o_nz_addr),
    .i_val_data (i_val_data),
    .i_col_data (i_col_data),
    .o_x_en     (o_x_en),
    .o_x_addr   (o_x_addr),
    .i_x_data   (i_x_data),
    .o_row_ptr  (o_row_ptr),
    .o_start    (o_start),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data_a   (o_data_a),
    .o_data_b   (o_data_b),
    .o_count    (o_count),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  logic [7:0]  ptr_mem [17];
  logic [15:0] val_mem [256];
  logic [3:0]  col_mem [256];
  logic [15:0] x_mem   [16];

  always @(posedge clk) begin
    if (o_ptr_en) i_ptr_data <= ptr_mem[o_ptr_addr];
    if (o_nz_en) begin
      i_val_data <= val_mem[o_nz_addr];
      i_col_data <= col_mem[o_nz_addr];
    end
    if (o_x_en) i_x_data <= x_mem[o_x_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0]  cnt;
    logic [15:0] a;
    logic [15:0] b;
  } xfer_t;

  typedef struct {
    row_ptr_t ptr;
    int       mode;
    bit       ident;
    bit       exp_err;
    int       exp_nnz;
  } vec_t;

  int    tests = 0;
  int    fails = 0;
  xfer_t got_q[$];
  int    n_start, n_done, n_nz, n_bad;
  int    start_cyc, go_cyc;
  bit    busy1, err1, err_done, timeout;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ready modes: 0 always high, 1 random, 2 stall element 2 for 5 cycles
  task automatic run_job(input int mode, input bit poke, input int rst_at);
    int    stall = 0;
    int    post = -1;
    bit    held = 0;
    bit    poked = 0;
    xfer_t hold = '0;
    xfer_t cur;
    got_q.delete();
    n_start = 0; n_done = 0; n_nz = 0; n_bad = 0;
    start_cyc = -1; timeout = 1;
    i_go = 1'b1;
    go_cyc = cyc;
    for (int g = 0; g < 4000; g++) begin
      @(negedge clk);
      i_go = 1'b0;
      if (g == 0) begin busy1 = o_busy; err1 = o_err; end
      if (o_start) begin n_start++; start_cyc = cyc; end
      if (o_nz_en) n_nz++;
      if (o_done) begin
        n_done++;
        if (post < 0) begin post = 3; err_done = o_err; end
      end
      case (mode)
        0: i_ready = 1'b1;
        1: i_ready = ($urandom_range(0, 3) != 0);
        default: begin
          i_ready = 1'b1;
          if (o_valid && o_count == 8'd2 && stall < 5) begin
            i_ready = 1'b0;
            stall++;
          end
        end
      endcase
      cur = {o_count, o_data_a, o_data_b};
      if (held && (!o_valid || cur != hold)) n_bad++;
      held = 0;
      if (o_valid) begin
        if (rst_at >= 0 && int'(o_count) == rst_at) begin
          i_rst = 1'b1;
          timeout = 0;
          return;
        end
        if (poke && !poked && o_count == 8'd1) begin
          i_go = 1'b1;
          poked = 1;
        end
        if (i_ready) got_q.push_back(cur);
        else begin held = 1; hold = cur; end
      end
      if (post == 0) begin timeout = 0; break; end
      if (post > 0) post--;
    end
  endtask

  function automatic bit model_err(input row_ptr_t p);
    bit e = (p[0] != 0);
    for (int i = 0; i < 17; i++)
      for (int j = i + 1; j < 17; j++)
        if (p[i] > p[j]) e = 1;
    return e;
  endfunction

  task automatic check_job(input string tag, input row_ptr_t p,
                           input bit exp_err, input int exp_nnz);
    int    n_x = exp_err ? 0 : exp_nnz;
    int    n_s = (n_x > 0) ? 1 : 0;
    int    m;
    xfer_t e;
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_busy"}, busy1, 1);
    chk({tag, "_err_clr"}, err1, 0);
    chk({tag, "_done"}, n_done, 1);
    chk({tag, "_start"}, n_start, n_s);
    if (n_s == 1) chk({tag, "_start_lat"}, start_cyc - go_cyc, 20);
    chk({tag, "_err"}, err_done, exp_err);
    chk({tag, "_err_sticky"}, o_err, exp_err);
    chk({tag, "_rowptr"}, o_row_ptr, p);
    chk({tag, "_nz_reads"}, n_nz, n_x);
    chk({tag, "_stable"}, n_bad, 0);
    chk({tag, "_nxfer"}, got_q.size(), n_x);
    m = (got_q.size() < n_x) ? got_q.size() : n_x;
    for (int i = 0; i < m; i++) begin
      e.cnt = 8'(i);
      e.a   = val_mem[i];
      e.b   = x_mem[col_mem[i]];
      chk($sformatf("%s_xfer%0d", tag, i), got_q[i], e);
    end
  endtask

  task automatic load_mem(input row_ptr_t p, input bit ident);
    logic [15:0] fp [16] = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200,
                             16'h4400, 16'h4500, 16'h4600, 16'h4700,
                             16'h4800, 16'h4880, 16'h4900, 16'h4980,
                             16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80};
    for (int i = 0; i < 17; i++) ptr_mem[i] = p[i];
    for (int i = 0; i < 256; i++) begin
      val_mem[i] = ident ? 16'h3C00 : 16'($urandom);
      col_mem[i] = ident ? 4'(i) : 4'($urandom);
    end
    for (int i = 0; i < 16; i++) x_mem[i] = ident ? fp[i] : 16'($urandom);
  endtask

  logic [255:0] outs;
  vec_t         vecs[7];
  row_ptr_t     p;
  int           n_bad_en;
  bit           e;

  always_comb
    outs = {55'd0, o_ptr_en, o_ptr_addr, o_nz_en, o_nz_addr, o_x_en,
            o_x_addr, o_row_ptr, o_start, o_valid, o_data_a, o_data_b,
            o_count, o_busy, o_done, o_err};

  initial begin
    for (int i = 0; i < 17; i++) begin
      vecs[0].ptr[i] = 8'(i);
      vecs[1].ptr[i] = 8'd0;
      vecs[2].ptr[i] = (i == 5) ? 8'd3 : 8'(i);
      vecs[3].ptr[i] = 8'(i + 1);
      vecs[4].ptr[i] = (i < 4) ? 8'(i) : 8'd4;
      vecs[5].ptr[i] = (i == 16) ? 8'd5 : 8'd0;
      vecs[6].ptr[i] = (i == 16) ? 8'd255 : 8'(i * 15);
    end
    vecs[0].mode = 0; vecs[0].ident = 1; vecs[0].exp_err = 0; vecs[0].exp_nnz = 16;
    vecs[1].mode = 0; vecs[1].ident = 0; vecs[1].exp_err = 0; vecs[1].exp_nnz = 0;
    vecs[2].mode = 1; vecs[2].ident = 0; vecs[2].exp_err = 1; vecs[2].exp_nnz = 16;
    vecs[3].mode = 1; vecs[3].ident = 0; vecs[3].exp_err = 1; vecs[3].exp_nnz = 17;
    vecs[4].mode = 2; vecs[4].ident = 0; vecs[4].exp_err = 0; vecs[4].exp_nnz = 4;
    vecs[5].mode = 1; vecs[5].ident = 0; vecs[5].exp_err = 0; vecs[5].exp_nnz = 5;
    vecs[6].mode = 1; vecs[6].ident = 0; vecs[6].exp_err = 0; vecs[6].exp_nnz = 255;

    repeat (3) @(negedge clk);
    chk("reset_outs", outs, 0);
    chk("reset_state", dut.state, IDLE);
    i_rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      load_mem(vecs[v].ptr, vecs[v].ident);
      run_job(vecs[v].mode, 0, -1);
      check_job($sformatf("vec%0d", v), vecs[v].ptr,
                vecs[v].exp_err, vecs[v].exp_nnz);
    end

    // go pulse while presenting must not disturb the walk
    load_mem(vecs[0].ptr, 1);
    run_job(0, 1, -1);
    check_job("poke_go", vecs[0].ptr, 0, 16);

    // reset while element 7 of 40 is presented
    for (int i = 0; i < 17; i++) p[i] = 8'((i * 5) / 2);
    load_mem(p, 0);
    run_job(1, 0, 7);
    chk("rst_hit", timeout, 0);
    @(negedge clk);
    chk("rst_mid_outs", outs, 0);
    chk("rst_mid_state", dut.state, IDLE);
    i_rst = 1'b0;
    n_bad_en = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_ptr_en || o_nz_en || o_x_en || o_done) n_bad_en++;
    end
    chk("rst_quiet", n_bad_en, 0);
    run_job(1, 0, -1);
    check_job("rst_rerun", p, 0, 40);

    for (int r = 0; r < 6; r++) begin
      p[0] = 8'd0;
      for (int i = 1; i < 17; i++) p[i] = p[i-1] + 8'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        int j = $urandom_range(1, 16);
        if (p[j-1] > 0) p[j] = p[j-1] - 8'd1;
        else p[0] = 8'd1;
      end
      e = model_err(p);
      load_mem(p, 0);
      run_job(1, 0, -1);
      check_job($sformatf("rnd%0d", r), p, e, int'(p[16]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
